hamming_frame_tx: RTL and testbench

Downstream serial transmit stage for the Hamming codec. It accepts finished codewords from the encoder over a valid/ready handshake and buffers them in a small FIFO. It shifts each codeword out on a single wire as an asynchronous frame: one start bit, the codeword LSB-first, then one stop bit. This is the off-chip link driven from a dedicated output pin of the top level.

---
 rtl/hamming_pkg.sv | 19 +
 rtl/hamming_cw_fifo.sv | 69 ++++++
 rtl/hamming_frame_tx.sv | 152 +++++++++++++++
 tb/tb_hamming_frame_tx.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming codec transmit path.
// Holds the serial-transmit FSM encoding and the legal codeword widths.
package hamming_pkg;

  localparam int HAM74_W    = 7;
  localparam int SECDED84_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic bit cw_width_ok(input int w);
    return (w == HAM74_W) || (w == SECDED84_W);
  endfunction

endpackage

// File: rtl/hamming_cw_fifo.sv
// Small synchronous FIFO buffering codewords ahead of the serial transmitter.
// The head entry is presented combinationally on dout_o while not empty.
module hamming_cw_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [DATA_W-1:0]              din_i,
  input  logic                           pop_i,
  output logic [DATA_W-1:0]              dout_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("hamming_cw_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Guards keep the occupancy count consistent even if a caller misbehaves.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/hamming_frame_tx.sv
// Serial transmit stage: buffers codewords and sends each as start bit,
// LSB-first codeword, stop bit on a registered, idle-high line.
module hamming_frame_tx
  import hamming_pkg::*;
#(
  parameter int CW_WIDTH     = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CW_WIDTH-1:0]               cw_in,
  input  logic                              cw_valid,
  output logic                              cw_ready,
  output logic                              tx_out,
  output logic                              tx_busy,
  output logic                              frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(CW_WIDTH);
  localparam logic [TW-1:0] T_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(CW_WIDTH - 1);

  if (!cw_width_ok(CW_WIDTH)) begin : g_bad_width
    $error("hamming_frame_tx: CW_WIDTH must be 7 or 8");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("hamming_frame_tx: CLKS_PER_BIT must be at least 1");
  end

  tx_state_e         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [CW_WIDTH-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW_WIDTH-1:0] fifo_head;
  logic              tmr_zero;

  // Readiness depends only on the stored count, so a same-cycle pop never
  // opens a slot for a simultaneous push while full.
  assign cw_ready  = ~fifo_full;
  assign fifo_push = cw_valid & cw_ready;

  hamming_cw_fifo #(
    .DATA_W (CW_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (cw_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tmr_zero   = (timer_q == '0);
  assign tx_out     = tx_q;
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = done_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          timer_d  = T_RELOAD;
          state_d  = START;
        end
      end
      START: begin
        if (tmr_zero) begin
          timer_d   = T_RELOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DATA: begin
        if (tmr_zero) begin
          timer_d = T_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STOP: begin
        if (tmr_zero) begin
          done_d  = 1'b1;
          timer_d = T_RELOAD;
          // Chain straight into the next frame so back-to-back frames abut.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state so tx_out is a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_hamming_frame_tx.sv
// Directed bench for hamming_frame_tx: an 8-bit/4-clock instance and a
// 7-bit/1-clock instance sharing clock and reset.
module tb_hamming_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] a_in;
  logic       a_valid, a_ready, a_tx, a_busy, a_done;
  logic [1:0] a_lvl;

  logic [6:0] b_in;
  logic       b_valid, b_ready, b_tx, b_busy, b_done;
  logic [1:0] b_lvl;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] dec_q [$];
  logic [6:0] exp_q [$];
  int         mon_cnt = 0;
  logic [6:0] mon_data = '0;
  int         mon_stop_err = 0;

  always #5 clk = ~clk;

  hamming_frame_tx #(.CW_WIDTH(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(2)) u_a (
    .clk(clk), .rst_n(rst_n), .cw_in(a_in), .cw_valid(a_valid), .cw_ready(a_ready),
    .tx_out(a_tx), .tx_busy(a_busy), .frame_done(a_done), .fifo_level(a_lvl)
  );

  hamming_frame_tx #(.CW_WIDTH(7), .CLKS_PER_BIT(1), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .cw_in(b_in), .cw_valid(b_valid), .cw_ready(b_ready),
    .tx_out(b_tx), .tx_busy(b_busy), .frame_done(b_done), .fifo_level(b_lvl)
  );

  // Independent line decoder for instance B (one sample per bit).
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt <= 0;
    end else if (mon_cnt == 0) begin
      if (b_tx == 1'b0) mon_cnt <= 1;
    end else if (mon_cnt <= 7) begin
      mon_data[mon_cnt-1] <= b_tx;
      mon_cnt <= mon_cnt + 1;
    end else begin
      if (b_tx == 1'b1) dec_q.push_back(mon_data);
      else mon_stop_err <= mon_stop_err + 1;
      mon_cnt <= 0;
    end
  end

  function automatic logic line_bit8(input logic [7:0] w, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return w[k-1];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_in = '0; b_in = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_tx, a_ready, a_busy, a_lvl, a_done, b_tx, b_ready, b_busy, b_lvl, b_done}
          !== {1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: a tx/rdy/busy/lvl/done=%b%b%b%0d%b b=%b%b%b%0d%b required 1110 0 / 1110 0",
                 i, a_tx, a_ready, a_busy, a_lvl, a_done, b_tx, b_ready, b_busy, b_lvl, b_done);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic       etx, edone;
    w = 8'hA5;
    a_in = w; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    n_cmp++;
    if ({a_tx, a_lvl} !== {1'b1, 2'd1}) begin
      n_bad++;
      $display("FAIL single_accept: tx=%b lvl=%0d required tx=1 lvl=1", a_tx, a_lvl);
    end
    for (int i = 0; i <= 41; i++) begin
      @(negedge clk);
      etx   = (i < 40) ? line_bit8(w, i / 4) : 1'b1;
      edone = (i == 40);
      n_cmp++;
      if ({a_tx, a_done} !== {etx, edone}) begin
        n_bad++;
        $display("FAIL single_line cyc %0d: tx=%b done=%b required tx=%b done=%b", i, a_tx, a_done, etx, edone);
      end
      if (i == 0) begin
        n_cmp++;
        if ({a_busy, a_lvl} !== {1'b1, 2'd0}) begin
          n_bad++;
          $display("FAIL single_busy: busy=%b lvl=%0d required busy=1 lvl=0", a_busy, a_lvl);
        end
      end
    end
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle: busy=%b required 0", a_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic       etx, edone;
    int         ndone;
    words[0] = 8'h3C; words[1] = 8'hFF; words[2] = 8'h00;
    ndone = 0;
    a_in = words[0]; a_valid = 1'b1;
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0: ready=%b required 1", a_ready); end
    @(negedge clk);
    a_in = words[1];
    n_cmp++;
    if ({a_ready, a_tx} !== 2'b11) begin n_bad++; $display("FAIL b2b_ready1: ready=%b tx=%b required 1 1", a_ready, a_tx); end
    @(negedge clk);
    a_in = words[2];
    n_cmp++;
    if (a_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready2: ready=%b required 1", a_ready); end
    for (int i = 0; i <= 120; i++) begin
      if (i == 1) begin
        a_valid = 1'b0;
        n_cmp++;
        if ({a_ready, a_lvl} !== {1'b0, 2'd2}) begin
          n_bad++;
          $display("FAIL b2b_full: ready=%b lvl=%0d required ready=0 lvl=2", a_ready, a_lvl);
        end
      end
      if (i == 40) begin
        n_cmp++;
        if ({a_ready, a_lvl} !== {1'b1, 2'd1}) begin
          n_bad++;
          $display("FAIL b2b_pop: ready=%b lvl=%0d required ready=1 lvl=1", a_ready, a_lvl);
        end
      end
      etx   = (i < 120) ? line_bit8(words[i / 40], (i % 40) / 4) : 1'b1;
      edone = (i == 40) || (i == 80) || (i == 120);
      if (a_done === 1'b1) ndone++;
      n_cmp++;
      if ({a_tx, a_done} !== {etx, edone}) begin
        n_bad++;
        $display("FAIL b2b_line cyc %0d: tx=%b done=%b required tx=%b done=%b", i, a_tx, a_done, etx, edone);
      end
      if (i < 120) @(negedge clk);
    end
    n_cmp++;
    if (ndone != 3) begin n_bad++; $display("FAIL b2b_done_count: %0d required 3", ndone); end
    @(negedge clk);
    n_cmp++;
    if ({a_tx, a_busy, a_done, a_lvl} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_bad++;
      $display("FAIL b2b_after: tx=%b busy=%b done=%b lvl=%0d required 1 0 0 0", a_tx, a_busy, a_done, a_lvl);
    end
  endtask

  task automatic test_w7();
    logic [6:0] w;
    logic       etx, edone;
    w = 7'h55;
    dec_q.delete();
    b_in = w; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    n_cmp++;
    if (b_tx !== 1'b1) begin n_bad++; $display("FAIL w7_accept: tx=%b required 1", b_tx); end
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      etx   = (i == 0) ? 1'b0 : (i <= 7) ? w[i-1] : 1'b1;
      edone = (i == 9);
      n_cmp++;
      if ({b_tx, b_done} !== {etx, edone}) begin
        n_bad++;
        $display("FAIL w7_line cyc %0d: tx=%b done=%b required tx=%b done=%b", i, b_tx, b_done, etx, edone);
      end
    end
    n_cmp++;
    if (dec_q.size() != 1 || dec_q[0] !== w) begin
      n_bad++;
      $display("FAIL w7_decode: size=%0d first=%h required size=1 first=%h",
               dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 7'h0, w);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    logic       etx, edone;
    a_in = 8'h5A; a_valid = 1'b1;
    @(negedge clk);
    a_in = 8'hC3;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if ({a_tx, a_lvl} !== {1'b0, 2'd1}) begin
      n_bad++;
      $display("FAIL midrst_before: tx=%b lvl=%0d required tx=0 lvl=1", a_tx, a_lvl);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_tx, a_lvl, a_ready, a_busy, a_done} !== {1'b1, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_async: tx=%b lvl=%0d rdy=%b busy=%b done=%b required 1 0 1 0 0",
               a_tx, a_lvl, a_ready, a_busy, a_done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_tx, a_busy, a_done, a_lvl} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
        n_bad++;
        $display("FAIL midrst_quiet cyc %0d: tx=%b busy=%b done=%b lvl=%0d required 1 0 0 0",
                 i, a_tx, a_busy, a_done, a_lvl);
      end
    end
    w = 8'h96;
    a_in = w; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i <= 45; i++) begin
      @(negedge clk);
      etx   = (i < 40) ? line_bit8(w, i / 4) : 1'b1;
      edone = (i == 40);
      n_cmp++;
      if ({a_tx, a_done} !== {etx, edone}) begin
        n_bad++;
        $display("FAIL midrst_resend cyc %0d: tx=%b done=%b required tx=%b done=%b", i, a_tx, a_done, etx, edone);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] w;
    int         n;
    int         stall;
    int         nwrong;
    bit         timed_out;
    dec_q.delete();
    exp_q.delete();
    timed_out = 1'b0;
    for (int k = 0; k < 1000 && !timed_out; k++) begin
      w = 7'($urandom_range(0, 127));
      b_in = w; b_valid = 1'b1;
      n = 0;
      while (b_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
        timed_out = 1'b1;
        n_cmp++; n_bad++;
        $display("FAIL rand_ready_timeout: word %0d ready=%b required 1", k, b_ready);
      end else begin
        @(posedge clk);
        exp_q.push_back(w);
        @(negedge clk);
        b_valid = 1'b0;
        stall = $urandom_range(0, 3);
        repeat (stall) @(negedge clk);
      end
    end
    b_valid = 1'b0;
    n = 0;
    while ((b_busy !== 1'b0 || b_lvl !== 2'd0) && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n >= 2000) begin n_bad++; $display("FAIL rand_drain_timeout: busy=%b lvl=%0d required 0 0", b_busy, b_lvl); end
    n_cmp++;
    if (dec_q.size() != exp_q.size() || exp_q.size() != 1000) begin
      n_bad++;
      $display("FAIL rand_count: decoded=%0d sent=%0d required 1000", dec_q.size(), exp_q.size());
    end
    nwrong = 0;
    for (int k = 0; k < exp_q.size() && k < dec_q.size(); k++)
      if (dec_q[k] !== exp_q[k]) nwrong++;
    n_cmp++;
    if (nwrong != 0) begin n_bad++; $display("FAIL rand_data: %0d words differ, required 0", nwrong); end
    n_cmp++;
    if (mon_stop_err != 0) begin n_bad++; $display("FAIL rand_stop: %0d bad stop bits, required 0", mon_stop_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    repeat (2) @(negedge clk);
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_w7();
    repeat (2) @(negedge clk);
    test_reset_mid_frame();
    repeat (2) @(negedge clk);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
